exe_stage: RTL
==============

Name: exe_stage

Overview:
Execute stage of the 5-stage in-order pipeline, sitting between ID and MEM.
- Latches the ID bundle and computes the ALU result through the existing combinational alu.
- Runs 32-bit signed and unsigned divide/modulo on an iterative multi-cycle divider, stalling the stage until the result is ready.
- Issues the data SRAM request for loads and stores.
- Produces the 103-bit EXE→MEM bus and an EXE forwarding/hazard bus back to ID.

Parameters:
ALU_OP_W, 12, width of one-hot ALU opcode
DIV_ITERS, 32, divider iteration count (must equal the data width, 32)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
id_exe_valid  in  1  ID holds a valid instruction
exe_allowin  out  1  EXE can accept this cycle
id_exe_bus  in  184  {alu_op[11:0], div_op[3:0], src1[31:0], src2[31:0], rkd_value[31:0], mem_we, res_from_mem, gr_we, dest[4:0], pc[31:0], inst[31:0]}, MSB first
exe_mem_valid  out  1  EXE result valid toward MEM
mem_allowin  in  1  MEM can accept
exe_mem_bus  out  103  {gr_we, res_from_mem, dest[4:0], pc[31:0], inst[31:0], result[31:0]}
data_sram_en  out  1  SRAM request enable
data_sram_we  out  4  byte write enables
data_sram_addr  out  32  byte address
data_sram_wdata  out  32  store data
exe_wr_bus  out  39  {exe_en_bypass, exe_res_from_mem, dest[4:0], result[31:0]} to ID

Behaviour:
- Clock and reset: clk is the clock; resetn is a synchronous, active-low reset.
- Reset values: exe_valid=0, divider state=IDLE, iteration count=0.
  - All outputs are then 0 except exe_allowin=1.
  - Bus register contents are don't-care; every use is gated by exe_valid.
- Handshake:
  - exe_ready_go = ~is_div | (div_state==DONE).
  - exe_mem_valid = exe_valid & exe_ready_go.
  - exe_allowin = ~exe_valid | (exe_ready_go & mem_allowin).
  - exe_valid loads id_exe_valid when exe_allowin.
  - The bus register loads only when id_exe_valid & exe_allowin.
- div_op is one-hot: [0] div.w, [1] mod.w, [2] div.wu, [3] mod.wu. is_div = |div_op.
- ALU path: result = alu(alu_op, src1, src2). Zero added latency; EXE is 1 cycle.
- Divider FSM (radix-2 restoring on absolute values):
  - IDLE→BUSY when exe_valid & is_div. Captures |src1|, |src2|, the quotient sign (s1^s2) and the remainder sign (s1); counter=0. Signs apply only to signed ops.
  - BUSY: one quotient bit per cycle. Counter increments; at DIV_ITERS-1 go to DONE.
  - DONE: holds quotient/remainder and applies the sign fix. Leaves to IDLE on the cycle exe_valid & mem_allowin (handoff).
  - Latency: 34 cycles in EXE with no back-pressure (entry/IDLE cycle + 32 BUSY + DONE).
- Divide result: result = quotient for div ops, remainder for mod ops.
- Divide by zero: quotient = 32'hFFFF_FFFF, remainder = src1. The normal iteration yields this naturally; sign fix is not applied for zero divisor.
- Signed overflow (-2^31 / -1): quotient = 32'h8000_0000, remainder = 0.
- Back-pressure: while mem_allowin=0, DONE holds its result and the SRAM request stays deasserted.
- Memory request:
  - data_sram_en = exe_valid & (mem_we | res_from_mem) & mem_allowin, so a request issues exactly once, on handoff.
  - data_sram_we = {4{mem_we & exe_valid & mem_allowin}}.
  - data_sram_addr = ALU result; data_sram_wdata = rkd_value.
- Forwarding: exe_en_bypass = exe_valid & gr_we. exe_wr_bus is valid even while the divider is busy; ID stalls on any EXE hit when ~exe_ready_go or res_from_mem.
- Reset mid-division: FSM returns to IDLE and the instruction is dropped. No SRAM request is issued.

Optional Feature:
EXE_DIV_SHORTCUT_EN
- Defined: IDLE goes directly to DONE next cycle (2-cycle divide) when the divisor is zero or |src1| < |src2|.
  - Quotient 0 (or all-ones for a zero divisor); remainder = src1.
- Undefined: every divide takes the full 34 cycles.

Decomposition:
- Shared package: bus widths (184, 103, 39), div_op bit indices, ALU op indices, divider state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
- Sub-module: exe_divider, holding the FSM and datapath with start/signed/done/quotient/remainder ports. The existing alu is instantiated unchanged.

Test Plan:
- add.w src1=5, src2=7, mem_allowin=1 → exe_mem_valid next cycle; result=12; exe_wr_bus={1,0,dest,12}.
- div.w -7/2, mod.w -7/2 → exe_ready_go after 34 cycles; quotient 32'hFFFF_FFFD, remainder 32'hFFFF_FFFF; exe_allowin=0 throughout.
- div.wu 100/0 → quotient 32'hFFFF_FFFF, mod.wu remainder 100. With EXE_DIV_SHORTCUT_EN, done in 2 cycles.
- st.w addr src1+offset=0x1000, rkd=0xDEADBEEF, mem_allowin low 3 cycles → no request while stalled; then one cycle of en=1, we=4'hF, addr=0x1000.
- ld.w → en=1, we=0, res_from_mem=1 in bus and exe_wr_bus.
- Reset asserted during BUSY cycle 10 → exe_valid=0, FSM IDLE. Next div starts fresh and completes in 34 cycles.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the EXE stage: bus layouts, opcode bit indices and divider states.
package exe_stage_pkg;

  localparam int unsigned IdExeBusW  = 184;
  localparam int unsigned ExeMemBusW = 103;
  localparam int unsigned ExeWrBusW  = 39;
  localparam int unsigned AluOpW     = 12;
  localparam int unsigned DivOpW     = 4;

  // div_op one-hot bit positions
  localparam int unsigned DivW  = 0;
  localparam int unsigned ModW  = 1;
  localparam int unsigned DivWu = 2;
  localparam int unsigned ModWu = 3;

  // alu_op one-hot bit positions
  localparam int unsigned AluAdd  = 0;
  localparam int unsigned AluSub  = 1;
  localparam int unsigned AluSlt  = 2;
  localparam int unsigned AluSltu = 3;
  localparam int unsigned AluAnd  = 4;
  localparam int unsigned AluNor  = 5;
  localparam int unsigned AluOr   = 6;
  localparam int unsigned AluXor  = 7;
  localparam int unsigned AluSll  = 8;
  localparam int unsigned AluSrl  = 9;
  localparam int unsigned AluSra  = 10;
  localparam int unsigned AluLui  = 11;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivBusy = 2'd1,
    DivDone = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [AluOpW-1:0] alu_op;
    logic [DivOpW-1:0] div_op;
    logic [31:0]       src1;
    logic [31:0]       src2;
    logic [31:0]       rkd_value;
    logic              mem_we;
    logic              res_from_mem;
    logic              gr_we;
    logic [4:0]        dest;
    logic [31:0]       pc;
    logic [31:0]       inst;
  } id_exe_bus_t;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU driven by a one-hot opcode; result is the OR of the gated per-op results.
module alu
  import exe_stage_pkg::*;
(
  input  logic [AluOpW-1:0] alu_op,
  input  logic [31:0]       alu_src1,
  input  logic [31:0]       alu_src2,
  output logic [31:0]       alu_result
);

  logic        sub_like;
  logic [31:0] adder_b;
  logic [32:0] adder_sum;
  logic        slt_res;
  logic        sltu_res;
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;

  assign sub_like  = alu_op[AluSub] | alu_op[AluSlt] | alu_op[AluSltu];
  assign adder_b   = sub_like ? ~alu_src2 : alu_src2;
  assign adder_sum = {1'b0, alu_src1} + {1'b0, adder_b} + {32'd0, sub_like};

  assign slt_res  = (alu_src1[31] & ~alu_src2[31]) |
                    (~(alu_src1[31] ^ alu_src2[31]) & adder_sum[31]);
  assign sltu_res = ~adder_sum[32];

  assign sll_res = alu_src1 << alu_src2[4:0];
  assign srl_res = alu_src1 >> alu_src2[4:0];
  assign sra_res = $signed(alu_src1) >>> alu_src2[4:0];

  always_comb begin
    alu_result = 32'd0;
    alu_result |= {32{alu_op[AluAdd] | alu_op[AluSub]}} & adder_sum[31:0];
    alu_result |= {32{alu_op[AluSlt]}}  & {31'd0, slt_res};
    alu_result |= {32{alu_op[AluSltu]}} & {31'd0, sltu_res};
    alu_result |= {32{alu_op[AluAnd]}}  & (alu_src1 & alu_src2);
    alu_result |= {32{alu_op[AluNor]}}  & ~(alu_src1 | alu_src2);
    alu_result |= {32{alu_op[AluOr]}}   & (alu_src1 | alu_src2);
    alu_result |= {32{alu_op[AluXor]}}  & (alu_src1 ^ alu_src2);
    alu_result |= {32{alu_op[AluSll]}}  & sll_res;
    alu_result |= {32{alu_op[AluSrl]}}  & srl_res;
    alu_result |= {32{alu_op[AluSra]}}  & sra_res;
    alu_result |= {32{alu_op[AluLui]}}  & alu_src2;
  end

endmodule

// File: rtl/exe_divider.sv
// Iterative radix-2 restoring divider on magnitudes with a final sign fix.
// EXE_DIV_SHORTCUT_EN: trivial divides (zero divisor or |src1| < |src2|) finish without iterating.
module exe_divider
  import exe_stage_pkg::*;
#(
  parameter int unsigned Iters = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic        ack_i,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  localparam int unsigned CntW = $clog2(Iters);

  div_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     quo_q, quo_d;
  logic [31:0]     rem_q, rem_d;
  logic [31:0]     dvs_q, dvs_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            dz_q, dz_d;

  logic [31:0] abs1;
  logic [31:0] abs2;
  logic        src2_zero;
  logic        shortcut;
  logic [32:0] trial;
  logic [32:0] diff;
  logic        ge;

  assign abs1      = abs32(src1_i, signed_i);
  assign abs2      = abs32(src2_i, signed_i);
  assign src2_zero = (src2_i == 32'd0);

`ifdef EXE_DIV_SHORTCUT_EN
  assign shortcut = src2_zero | (abs1 < abs2);
`else
  assign shortcut = 1'b0;
`endif

  // Quotient register doubles as the dividend shifter: its MSB feeds the partial remainder.
  assign trial = {rem_q, quo_q[31]};
  assign diff  = trial - {1'b0, dvs_q};
  assign ge    = (trial >= {1'b0, dvs_q});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    unique case (state_q)
      DivIdle: begin
        if (start_i) begin
          dvs_d   = abs2;
          q_neg_d = signed_i & (src1_i[31] ^ src2_i[31]);
          r_neg_d = signed_i & src1_i[31];
          dz_d    = src2_zero;
          cnt_d   = '0;
          if (shortcut) begin
            quo_d   = {32{src2_zero}};
            rem_d   = abs1;
            state_d = DivDone;
          end else begin
            quo_d   = abs1;
            rem_d   = 32'd0;
            state_d = DivBusy;
          end
        end
      end
      DivBusy: begin
        quo_d = {quo_q[30:0], ge};
        rem_d = ge ? diff[31:0] : trial[31:0];
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(Iters - 1)) begin
          state_d = DivDone;
        end
      end
      DivDone: begin
        if (ack_i) begin
          state_d = DivIdle;
        end
      end
      default: state_d = DivIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= DivIdle;
      cnt_q   <= '0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      dvs_q   <= 32'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
    end
  end

  // A zero divisor keeps the all-ones quotient; the remainder fix restores the original src1.
  assign done_o      = (state_q == DivDone);
  assign quotient_o  = (q_neg_q && !dz_q) ? (32'd0 - quo_q) : quo_q;
  assign remainder_o = r_neg_q ? (32'd0 - rem_q) : rem_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, multi-cycle divide, data SRAM request, EXE->MEM and forwarding buses.
// The divider honours EXE_DIV_SHORTCUT_EN for early completion of trivial divides.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int unsigned ALU_OP_W  = 12,
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  id_exe_valid,
  output logic                  exe_allowin,
  input  logic [IdExeBusW-1:0]  id_exe_bus,
  output logic                  exe_mem_valid,
  input  logic                  mem_allowin,
  output logic [ExeMemBusW-1:0] exe_mem_bus,
  output logic                  data_sram_en,
  output logic [3:0]            data_sram_we,
  output logic [31:0]           data_sram_addr,
  output logic [31:0]           data_sram_wdata,
  output logic [ExeWrBusW-1:0]  exe_wr_bus
);

  logic        exe_valid_q;
  id_exe_bus_t id_exe_bus_q;

  logic [ALU_OP_W-1:0] alu_op;
  logic [31:0]         alu_result;
  logic                is_div;
  logic                div_signed;
  logic                div_sel_quo;
  logic                div_done;
  logic [31:0]         div_quotient;
  logic [31:0]         div_remainder;
  logic                exe_ready_go;
  logic                handoff;
  logic [31:0]         exe_result;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      exe_valid_q <= 1'b0;
    end else if (exe_allowin) begin
      exe_valid_q <= id_exe_valid;
    end
  end

  // Cleared on reset so every output reads zero before the first instruction arrives.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      id_exe_bus_q <= '0;
    end else if (id_exe_valid && exe_allowin) begin
      id_exe_bus_q <= id_exe_bus;
    end
  end

  assign alu_op      = id_exe_bus_q.alu_op;
  assign is_div      = |id_exe_bus_q.div_op;
  assign div_signed  = id_exe_bus_q.div_op[DivW] | id_exe_bus_q.div_op[ModW];
  assign div_sel_quo = id_exe_bus_q.div_op[DivW] | id_exe_bus_q.div_op[DivWu];

  alu u_alu (
    .alu_op     (alu_op),
    .alu_src1   (id_exe_bus_q.src1),
    .alu_src2   (id_exe_bus_q.src2),
    .alu_result (alu_result)
  );

  exe_divider #(
    .Iters (DIV_ITERS)
  ) u_divider (
    .clk_i       (clk),
    .rst_ni      (resetn),
    .start_i     (exe_valid_q & is_div),
    .signed_i    (div_signed),
    .src1_i      (id_exe_bus_q.src1),
    .src2_i      (id_exe_bus_q.src2),
    .ack_i       (handoff),
    .done_o      (div_done),
    .quotient_o  (div_quotient),
    .remainder_o (div_remainder)
  );

  assign exe_ready_go  = ~is_div | div_done;
  assign exe_mem_valid = exe_valid_q & exe_ready_go;
  assign exe_allowin   = ~exe_valid_q | (exe_ready_go & mem_allowin);
  assign handoff       = exe_valid_q & mem_allowin;

  assign exe_result = is_div ? (div_sel_quo ? div_quotient : div_remainder) : alu_result;

  assign exe_mem_bus = {id_exe_bus_q.gr_we, id_exe_bus_q.res_from_mem, id_exe_bus_q.dest,
                        id_exe_bus_q.pc, id_exe_bus_q.inst, exe_result};

  // Requests fire only on the handoff cycle so a stalled access is never issued twice.
  assign data_sram_en    = handoff & (id_exe_bus_q.mem_we | id_exe_bus_q.res_from_mem);
  assign data_sram_we    = {4{id_exe_bus_q.mem_we & handoff}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = id_exe_bus_q.rkd_value;

  assign exe_wr_bus = {exe_valid_q & id_exe_bus_q.gr_we, id_exe_bus_q.res_from_mem,
                       id_exe_bus_q.dest, exe_result};

endmodule
